// File: rtl/core2wb_bridge.sv
// -----------------------------------------------------------------------------
// core2wb_bridge
//
// Converts an Ibex-style req/gnt/rvalid port into a Wishbone B4 pipelined
// master. Requests go straight through to the bus with no register stage.
// The bridge counts the transfers that are in flight and holds new requests
// back when the bus stalls or when MAX_OUTSTANDING transfers are already
// pending. If no response arrives for TIMEOUT cycles while transfers are
// pending, the oldest transfer is retired with an error.
//
// Handshakes:
//   core request : req_i is valid and gnt_o is ready. A transfer is accepted
//                  in every cycle where req_i & gnt_o are both high. The core
//                  holds we/be/addr/wdata stable until it sees gnt_o.
//   core response: rvalid_o is a single-cycle pulse with no back-pressure.
//                  rdata_o and err_o are only meaningful while rvalid_o=1.
//   wishbone     : the address phase completes when stb & ~stall. The data
//                  phase completes on ack or err, in issue order.
//
// Parameters:
//   MAX_OUTSTANDING  accepted but unacknowledged transfers allowed (1..15)
//   TIMEOUT          cycles without ACK/ERR before a synthetic error
//                    (0 disables the timeout)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_i/gnt_o                 core request handshake
//   we_i/be_i/addr_i/wdata_i    core request payload
//   rvalid_o/rdata_o/err_o      core response
//   wb_cyc_o..wb_dat_o          Wishbone master request outputs
//   wb_dat_i/ack_i/err_i        Wishbone response inputs
//   wb_stall_i                  Wishbone pipeline stall
//   proto_err_o                 sticky flag, set by ACK/ERR with nothing pending
// -----------------------------------------------------------------------------
module core2wb_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // core side
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  // wishbone side
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,
  // status
  output logic        proto_err_o
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             busy;
  logic             full;
  logic             accept;
  logic             resp;
  logic             tout;
  logic             done;

  assign busy = (cnt != '0);
  assign full = (cnt == CNT_MAX);

  // ---------------------------------------------------------------------------
  // Request path (combinational, zero latency)
  // ---------------------------------------------------------------------------
  assign wb_stb_o = req_i & ~full;
  assign gnt_o    = wb_stb_o & ~wb_stall_i;
  assign accept   = gnt_o;

  // CYC stays up while anything is pending, so the slave keeps the cycle
  // open until the last response comes back or the timer gives up on it.
  assign wb_cyc_o = wb_stb_o | busy;

  assign wb_we_o  = we_i;
  assign wb_adr_o = addr_i;
  assign wb_sel_o = be_i;
  assign wb_dat_o = wdata_i;

  // ---------------------------------------------------------------------------
  // Response path (combinational)
  // ---------------------------------------------------------------------------
  // A response only counts when something is outstanding. ACK and ERR in the
  // same cycle are a single completion, and that completion reports an error.
  assign resp     = (wb_ack_i | wb_err_i) & busy;
  assign done     = resp | tout;

  assign rvalid_o = done;
  assign err_o    = (wb_err_i & resp) | (tout & ~resp);
  assign rdata_o  = (wb_ack_i & resp) ? wb_dat_i : 32'h0;

  // ---------------------------------------------------------------------------
  // Outstanding-transfer counter
  // ---------------------------------------------------------------------------
  // Accept is blocked when full and completion needs busy, so the counter
  // can neither overflow nor underflow.
  always_comb begin
    cnt_next = cnt;
    if (accept && !done) begin
      cnt_next = cnt + CNT_ONE;
    end else if (!accept && done) begin
      cnt_next = cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Response timeout
  // ---------------------------------------------------------------------------
  // The timer measures quiet time: cycles with something pending and no
  // response. Each timeout retires only the oldest transfer and restarts the
  // timer, so every remaining transfer gets its own full window.
  if (TIMEOUT > 0) begin : g_tmr
    localparam int unsigned      TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    logic [TMR_W-1:0] tmr;

    // A real response in the same cycle takes priority over the timeout.
    assign tout = (tmr == TMR_MAX) & busy & ~resp;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tmr <= '0;
      end else if (resp || tout || !busy) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + TMR_ONE;
      end
    end
  end else begin : g_no_tmr
    assign tout = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Protocol error flag
  // ---------------------------------------------------------------------------
  // An ACK or ERR with nothing outstanding is dropped, not forwarded to the
  // core. The flag stays set until reset so software can see that it happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_o <= 1'b0;
    end else if ((wb_ack_i || wb_err_i) && !busy) begin
      proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core2wb_bridge.sv
// -----------------------------------------------------------------------------
// tb_core2wb_bridge
//
// Directed scenarios, then randomized traffic, for core2wb_bridge with
// MAX_OUTSTANDING=2 and TIMEOUT=8. The reference model keeps a queue of
// accepted transfers and a quiet-cycle count, and it predicts every output
// in every cycle. The slave model answers in issue order, using data derived
// from each transfer's address.
// -----------------------------------------------------------------------------
module tb_core2wb_bridge;

  localparam int MAXO = 2;
  localparam int TMO  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, wb_stall_i, proto_err_o;

  core2wb_bridge #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i), .proto_err_o(proto_err_o)
  );

  // ---------------- scoreboard / model state ----------------
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_q[$];    // expected read data per outstanding transfer, issue order
  logic [31:0] pend_q[$];   // slave view: addresses awaiting a response
  int          m_cnt;       // transfers outstanding
  int          m_quiet;     // consecutive pending cycles without a response
  bit          m_proto;

  // outputs observed in the most recent tick
  logic        l_gnt, l_stb, l_cyc, l_rvalid, l_err, l_proto;
  logic [31:0] l_rdata;

  int k, n_rv;

  // slave memory contents
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_q.delete();
    m_cnt   = 0;
    m_quiet = 0;
    m_proto = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit stall, input bit ack, input bit err);
    req_i      = req;
    we_i       = we;
    be_i       = be;
    addr_i     = addr;
    wdata_i    = wd;
    wb_stall_i = stall;
    wb_ack_i   = ack;
    wb_err_i   = err;
    // the slave answers for the oldest pending transfer
    wb_dat_i   = (ack && pend_q.size() > 0) ? mem_f(pend_q[0]) : $urandom();
  endtask

  // One clock cycle: called just after a falling edge with inputs driven.
  // Checks outputs against the model, then advances the model across the
  // rising edge and returns at the next falling edge.
  task automatic tick();
    bit          e_full, e_stb, e_gnt, e_cyc, e_resp, e_tout, e_rv, e_err;
    logic [31:0] e_rdata;
    #1;
    e_full  = (m_cnt == MAXO);
    e_stb   = req_i && !e_full;
    e_gnt   = e_stb && !wb_stall_i;
    e_cyc   = e_stb || (m_cnt > 0);
    e_resp  = (wb_ack_i || wb_err_i) && (m_cnt > 0);
    e_tout  = (m_quiet == TMO) && (m_cnt > 0) && !e_resp;
    e_rv    = e_resp || e_tout;
    e_err   = (wb_err_i && e_resp) || (e_tout && !e_resp);
    e_rdata = (wb_ack_i && e_resp) ? exp_q[0] : 32'h0;

    check("gnt",       gnt_o,       e_gnt);
    check("stb",       wb_stb_o,    e_stb);
    check("cyc",       wb_cyc_o,    e_cyc);
    check("rvalid",    rvalid_o,    e_rv);
    check("err",       err_o,       e_err);
    check("rdata",     rdata_o,     e_rdata);
    check("adr",       wb_adr_o,    addr_i);
    check("sel",       wb_sel_o,    be_i);
    check("we",        wb_we_o,     we_i);
    check("wdat",      wb_dat_o,    wdata_i);
    check("proto_err", proto_err_o, m_proto);

    l_gnt = gnt_o; l_stb = wb_stb_o; l_cyc = wb_cyc_o;
    l_rvalid = rvalid_o; l_err = err_o; l_rdata = rdata_o; l_proto = proto_err_o;

    @(posedge clk);
    if (e_rv) begin
      void'(exp_q.pop_front());
      void'(pend_q.pop_front());
    end
    if (e_gnt) begin
      exp_q.push_back(mem_f(addr_i));
      pend_q.push_back(addr_i);
    end
    if (e_resp || e_tout || m_cnt == 0) m_quiet = 0;
    else                                m_quiet = m_quiet + 1;
    if ((wb_ack_i || wb_err_i) && m_cnt == 0) m_proto = 1'b1;
    m_cnt = m_cnt + int'(e_gnt) - int'(e_rv);
    @(negedge clk);
  endtask

  task automatic idle(input bit ack, input bit err);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, ack, err);
  endtask

  task automatic single_read(input string pfx);
    drive(1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check({pfx, "_gnt"}, l_gnt, 1'b1);
    idle(1'b1, 1'b0);
    tick();
    check({pfx, "_rvalid"}, l_rvalid, 1'b1);
    check({pfx, "_rdata"},  l_rdata,  32'hDEAD_BEEF);
    check({pfx, "_err"},    l_err,    1'b0);
    idle(1'b0, 1'b0);
    tick();
    check({pfx, "_cyc_low"}, l_cyc, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    idle(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_gnt",    gnt_o,       1'b0);
    check("rst_stb",    wb_stb_o,    1'b0);
    check("rst_cyc",    wb_cyc_o,    1'b0);
    check("rst_rvalid", rvalid_o,    1'b0);
    check("rst_err",    err_o,       1'b0);
    check("rst_proto",  proto_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // single read
    single_read("sr");

    // back-to-back writes against the depth limit, first ACK 3 cycles late
    n_rv = 0;
    drive(1'b1, 1'b1, 4'hF, 32'h2000, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    tick(); check("b2b_gnt0", l_gnt, 1'b1); n_rv += int'(l_rvalid);
    drive(1'b1, 1'b1, 4'hF, 32'h2004, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    tick(); check("b2b_gnt1", l_gnt, 1'b1); n_rv += int'(l_rvalid);
    drive(1'b1, 1'b1, 4'hF, 32'h2008, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    tick(); check("b2b_gnt2_full", l_gnt, 1'b0); check("b2b_stb2_full", l_stb, 1'b0);
    n_rv += int'(l_rvalid);
    drive(1'b1, 1'b1, 4'hF, 32'h2008, 32'h3333_3333, 1'b0, 1'b1, 1'b0);
    tick(); check("b2b_gnt3_ackcyc", l_gnt, 1'b0); n_rv += int'(l_rvalid);
    drive(1'b1, 1'b1, 4'hF, 32'h2008, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    tick(); check("b2b_gnt4_resume", l_gnt, 1'b1); n_rv += int'(l_rvalid);
    idle(1'b1, 1'b0); tick(); n_rv += int'(l_rvalid);
    idle(1'b1, 1'b0); tick(); n_rv += int'(l_rvalid);
    check("b2b_rvalid_count", n_rv, 3);
    idle(1'b0, 1'b0); tick(); check("b2b_cyc_low", l_cyc, 1'b0);

    // stall for 4 cycles with the request held
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'h3, 32'h3000, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("stall_gnt", l_gnt, 1'b0);
      check("stall_stb", l_stb, 1'b1);
    end
    drive(1'b1, 1'b0, 4'h3, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check("stall_release_gnt", l_gnt, 1'b1);
    idle(1'b1, 1'b0); tick(); check("stall_resp", l_rvalid, 1'b1);

    // timeout: one read, never acknowledged
    drive(1'b1, 1'b0, 4'hF, 32'h4000, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check("to_gnt", l_gnt, 1'b1);
    k = 1;
    while (k <= 20) begin
      idle(1'b0, 1'b0);
      tick();
      if (l_rvalid) break;
      k++;
    end
    check("to_latency", k, 9);
    check("to_err",   l_err,   1'b1);
    check("to_rdata", l_rdata, 32'h0);
    idle(1'b0, 1'b0); tick(); check("to_cyc_low", l_cyc, 1'b0);

    // accept and ACK in the same cycle; then ERR; then ACK+ERR together
    drive(1'b1, 1'b0, 4'hF, 32'h5000, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'hF, 32'h5004, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    check("sim_gnt", l_gnt, 1'b1); check("sim_rvalid", l_rvalid, 1'b1);
    idle(1'b0, 1'b1); tick();
    check("wberr_rvalid", l_rvalid, 1'b1); check("wberr_err", l_err, 1'b1);
    idle(1'b0, 1'b0); tick(); check("sim_cyc_low", l_cyc, 1'b0);
    drive(1'b1, 1'b1, 4'hC, 32'h5008, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0); tick();
    idle(1'b1, 1'b1); tick();
    check("both_rvalid", l_rvalid, 1'b1); check("both_err", l_err, 1'b1);
    idle(1'b0, 1'b0); tick(); check("both_cyc_low", l_cyc, 1'b0);

    // stray ACK with nothing outstanding
    idle(1'b1, 1'b0); tick(); check("stray_rvalid", l_rvalid, 1'b0);
    idle(1'b0, 1'b0); tick(); check("stray_proto", l_proto, 1'b1);

    // reset with two transfers in flight
    drive(1'b1, 1'b0, 4'hF, 32'h6000, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'hF, 32'h6004, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    idle(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cyc",    wb_cyc_o,    1'b0);
    check("arst_stb",    wb_stb_o,    1'b0);
    check("arst_gnt",    gnt_o,       1'b0);
    check("arst_rvalid", rvalid_o,    1'b0);
    check("arst_err",    err_o,       1'b0);
    check("arst_proto",  proto_err_o, 1'b0);
    model_reset();
    @(negedge clk);
    idle(1'b0, 1'b0);
    rst_n = 1'b1;
    single_read("post_rst");

    // randomized traffic, decreasing response rate to provoke timeouts
    for (int ph = 0; ph < 3; ph++) begin
      int ack_pct;
      ack_pct = (ph == 0) ? 60 : (ph == 1) ? 25 : 4;
      for (int c = 0; c < 600; c++) begin
        bit r_ack, r_err;
        int kind;
        r_ack = 1'b0;
        r_err = 1'b0;
        if (pend_q.size() > 0 && $urandom_range(0, 99) < ack_pct) begin
          kind = $urandom_range(0, 3);
          r_ack = (kind != 2);
          r_err = (kind >= 2);
        end else if (pend_q.size() == 0 && $urandom_range(0, 999) < 3) begin
          r_ack = 1'b1;
        end
        drive($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)), $urandom() & 32'hFFFF_FFFC, $urandom(),
              $urandom_range(0, 99) < 25, r_ack, r_err);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/core2wb_bridge.md
Name: core2wb_bridge

Overview:
Converts the Ibex core's req/gnt/rvalid bus protocol (one instance each for the instruction and data ports) into a Wishbone B4 pipelined master. It sits directly upstream of the shared-bus interconnect and drives one of its master ports. It tracks outstanding transfers, throttles on STALL and on a configurable depth limit, and ends hung transfers with a synthetic error response after a timeout.

Parameters:
MAX_OUTSTANDING, 2, maximum number of accepted, unacknowledged transfers (1..15)
TIMEOUT, 255, cycles without ACK/ERR while transfers are pending before a synthetic error is returned; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_i  in  1  core request valid
gnt_o  out  1  request accepted this cycle
we_i  in  1  write enable
be_i  in  4  byte enables
addr_i  in  32  byte address
wdata_i  in  32  write data
rvalid_o  out  1  response valid
rdata_o  out  32  read data
err_o  out  1  response error, qualified by rvalid_o
wb_cyc_o  out  1  Wishbone CYC
wb_stb_o  out  1  Wishbone STB
wb_we_o  out  1  Wishbone WE
wb_adr_o  out  32  Wishbone ADR
wb_sel_o  out  4  Wishbone SEL
wb_dat_o  out  32  Wishbone write data
wb_dat_i  in  32  Wishbone read data
wb_ack_i  in  1  Wishbone ACK
wb_err_i  in  1  Wishbone ERR
wb_stall_i  in  1  Wishbone STALL
proto_err_o  out  1  sticky flag: ACK/ERR received with no transfer outstanding

Behaviour:
- Reset values: cnt=0, tmr=0, proto_err_o=0. Therefore wb_cyc_o=0, wb_stb_o=0, gnt_o=0, rvalid_o=0, err_o=0. Reset asserted mid-transfer drops CYC immediately; in-flight responses are lost.
- cnt has width $clog2(MAX_OUTSTANDING+1) and holds the number of outstanding transfers. full = (cnt==MAX_OUTSTANDING).
- Request path is combinational, zero latency:
  - wb_stb_o = req_i & ~full.
  - wb_adr_o/wb_sel_o/wb_we_o/wb_dat_o = addr_i/be_i/we_i/wdata_i, passed through.
  - gnt_o = wb_stb_o & ~wb_stall_i.
  - wb_cyc_o = wb_stb_o | (cnt!=0).
- Acceptance: accept = gnt_o. The address phase completes in the same cycle.
- Response path is combinational:
  - resp = (wb_ack_i | wb_err_i) & (cnt!=0).
  - rvalid_o = resp | tout.
  - err_o = (wb_err_i & resp) | (tout & ~resp).
  - rdata_o = wb_dat_i when wb_ack_i & resp, else 0.
- Counter update:
  - cnt += accept; cnt -= (resp | tout).
  - Accept and completion in the same cycle leave cnt unchanged.
  - cnt never exceeds MAX_OUTSTANDING and never goes below 0.
- Timeout (TIMEOUT>0):
  - tmr has width $clog2(TIMEOUT+1). It resets to 0 on any resp or when cnt==0; otherwise it increments.
  - tout = (tmr==TIMEOUT) & (cnt!=0) & ~resp. A real response in the same cycle wins.
  - On tout: one transfer is retired with err_o=1, rdata_o=0, tmr returns to 0. Remaining transfers each time out separately.
  - If cnt reaches 0 via a timeout while req_i=0, CYC drops (bus abort).
- Stray response: ACK/ERR while cnt==0 produces no rvalid_o and sets proto_err_o=1 until reset.
- ACK and ERR asserted together count as one completion, reported as an error (err_o=1).
- Ordering: responses are returned to the core in issue order. The interconnect delivers them in order.
- No register stage on the request path; gnt_o may depend combinationally on wb_stall_i.

Test Plan:
- Single read: req_i=1, addr_i=0x1000, stall=0; ACK with dat_i=0xDEADBEEF the next cycle -> gnt_o=1 in cycle 0; rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0 in cycle 1; CYC low in cycle 2.
- Back-to-back writes with MAX_OUTSTANDING=2, ACK delayed 3 cycles: third request -> gnt_o=0 and wb_stb_o=0 while cnt=2; resumes the cycle after the first ACK; 3 rvalid_o pulses in order.
- Stall: wb_stall_i=1 for 4 cycles with req_i held -> gnt_o=0, wb_stb_o=1, address stable, cnt=0; gnt_o=1 in the cycle stall falls.
- Timeout with TIMEOUT=8: one accepted read, no ACK -> rvalid_o=1, err_o=1, rdata_o=0 exactly 9 cycles after accept (tmr 0..8); cnt=0, CYC low the next cycle.
- Simultaneous events: ACK in the same cycle as a new accept leaves cnt unchanged. WB ERR -> err_o=1. Stray ACK with cnt=0 -> proto_err_o=1 and no rvalid_o.
- Reset mid-operation: rst_n low with cnt=2 -> all outputs 0 asynchronously; after release, the first request behaves as in the single-read scenario.
